// File: rtl/fanout_repeater_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : fanout_repeater_arbiter_if
// Brief    : Driver/load handshake bundle for the fanout repeater arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface fanout_repeater_arbiter_if #(
    parameter int WIDTH = 8
);
    logic [2:0]       req;
    logic [2:0]       gnt;
    logic             drv_valid;
    logic [WIDTH-1:0] drv_data;
    logic             drv_ready;
    logic [2:0]       out_valid;
    logic [WIDTH-1:0] out_data;
    logic [2:0]       out_ready;

    modport master (
        output req, drv_valid, drv_data, out_ready,
        input  gnt, drv_ready, out_valid, out_data
    );

    modport slave (
        input  req, drv_valid, drv_data, out_ready,
        output gnt, drv_ready, out_valid, out_data
    );
endinterface
`default_nettype wire

// File: rtl/fanout_repeater_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fanout_repeater_arbiter
// Brief    : Round-robin sharing of one driver among three loads, carried
//            through a destination-tagged repeater pipeline.
// Revision : 1.0 - initial release
// ============================================================================
module fanout_repeater_arbiter #(
    parameter int WIDTH    = 8,
    parameter int STAGES   = 2,
    parameter int HOLD_MAX = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    fanout_repeater_arbiter_if.slave      bus
);

    localparam int c_cnt_w = $clog2(HOLD_MAX + 1);
    localparam int c_head  = STAGES - 1;
    localparam logic [c_cnt_w-1:0] c_hold_max = c_cnt_w'(HOLD_MAX);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    state_t                       r_state, w_state_nxt;
    logic [1:0]                   r_idx, w_idx_nxt;
    logic [1:0]                   r_ptr, w_ptr_nxt;
    logic [2:0]                   r_gnt, w_gnt_nxt;
    logic [c_cnt_w-1:0]           r_cnt, w_cnt_nxt, w_cnt_inc;
    logic [STAGES-1:0]            r_valid;
    logic [STAGES-1:0][WIDTH-1:0] r_data;
    logic [STAGES-1:0][1:0]       r_dest;

    logic       w_head_ready;
    logic       w_advance;
    logic       w_own;
    logic       w_others;
    logic       w_accept;
    logic       w_limit;
    logic [2:0] w_pick;

    function automatic logic [2:0] f_onehot(input logic [1:0] idx);
        f_onehot = 3'b001 << idx;
    endfunction

    function automatic logic [1:0] f_next(input logic [1:0] idx);
        f_next = (idx == 2'd2) ? 2'd0 : idx + 2'd1;
    endfunction

    // Returns {found, index}; scans downward so the lowest offset from base wins.
    function automatic logic [2:0] f_pick(input logic [2:0] reqs, input logic [1:0] base);
        logic [2:0] pos;
        f_pick = 3'b000;
        for (int n = 2; n >= 0; n--) begin
            pos = {1'b0, base} + 3'(n);
            if (pos >= 3'd3) pos = pos - 3'd3;
            if (reqs[pos[1:0]]) f_pick = {1'b1, pos[1:0]};
        end
    endfunction

    always_comb begin
        w_head_ready = 1'b0;
        case (r_dest[c_head])
            2'd0:    w_head_ready = bus.out_ready[0];
            2'd1:    w_head_ready = bus.out_ready[1];
            2'd2:    w_head_ready = bus.out_ready[2];
            default: w_head_ready = 1'b0;
        endcase
    end

    // The whole pipe moves as one: only the head's load can stall it.
    assign w_advance     = !r_valid[c_head] || w_head_ready;
    assign w_own         = |(r_gnt & bus.req);
    assign w_others      = |(~r_gnt & bus.req);
    assign bus.drv_ready = w_advance && w_own;
    assign w_accept      = bus.drv_valid && bus.drv_ready;
    assign w_cnt_inc     = (w_accept && (r_cnt != c_hold_max)) ? r_cnt + c_cnt_w'(1) : r_cnt;
    // Counting this cycle's beat lets the grant hand over with no bubble.
    assign w_limit       = (w_cnt_inc == c_hold_max);

    assign bus.gnt      = r_gnt;
    assign bus.out_data = r_data[c_head];

    always_comb begin
        bus.out_valid = 3'b000;
        if (r_valid[c_head]) bus.out_valid = f_onehot(r_dest[c_head]);
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_gnt_nxt   = r_gnt;
        w_ptr_nxt   = r_ptr;
        w_cnt_nxt   = r_cnt;
        w_pick      = 3'b000;
        case (r_state)
            S_IDLE: begin
                w_pick = f_pick(bus.req, r_ptr);
                if (w_pick[2]) begin
                    w_state_nxt = S_GRANT;
                    w_idx_nxt   = w_pick[1:0];
                    w_gnt_nxt   = f_onehot(w_pick[1:0]);
                    w_cnt_nxt   = '0;
                end
            end
            S_GRANT: begin
                if (!w_own || (w_limit && w_others)) begin
                    w_ptr_nxt = f_next(r_idx);
                    w_pick    = f_pick(bus.req & ~r_gnt, f_next(r_idx));
                    w_cnt_nxt = '0;
                    if (w_pick[2]) begin
                        w_idx_nxt = w_pick[1:0];
                        w_gnt_nxt = f_onehot(w_pick[1:0]);
                    end else begin
                        w_state_nxt = S_IDLE;
                        w_gnt_nxt   = 3'b000;
                    end
                end else if (w_limit) begin
                    w_cnt_nxt = '0;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_gnt_nxt   = 3'b000;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_idx   <= 2'd0;
            r_ptr   <= 2'd0;
            r_gnt   <= 3'b000;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_ptr   <= w_ptr_nxt;
            r_gnt   <= w_gnt_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
            r_data  <= '0;
            r_dest  <= '0;
        end else if (w_advance) begin
            r_valid[0] <= w_accept;
            if (w_accept) begin
                r_data[0] <= bus.drv_data;
                r_dest[0] <= r_idx;
            end
            for (int k = 1; k < STAGES; k++) begin
                r_valid[k] <= r_valid[k-1];
                r_data[k]  <= r_data[k-1];
                r_dest[k]  <= r_dest[k-1];
            end
        end
    end

endmodule
`default_nettype wire
